// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end control: button synchronise/debounce, IDLE/RUN/LAP/STOP
// sequencing, count-tick prescaler and the control strobes for the digit chain.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | stopped at zero, waiting for start
//  RUN   | counting, display follows the digits
//  LAP   | counting underneath, display latches frozen
//  STOP  | counting paused, partial tick kept in the prescaler
module stopwatch_ctrl #(
    parameter int DIV     = 500000,
    parameter int DEB_CYC = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_ss,
    input  logic btn_lr,
    output logic ad,
    output logic stp,
    output logic clr,
    output logic lap_hold
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_LAP  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    localparam int PW = $clog2(DIV);
    localparam int CW = $clog2(DEB_CYC + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] DEB_LOAD = CW'(DEB_CYC - 1);

    // index 0 = start/stop, index 1 = lap/reset
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_d;
    logic [1:0]    armed;
    logic [1:0]    ev;
    logic [1:0]    fill;
    logic [CW-1:0] cnt [0:1];

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic          ev_ss;
    logic          ev_lr;
    logic          run_now;
    logic          run_nx;
    logic [PW-1:0] presc;

    assign raw   = {btn_lr, btn_ss};
    assign ev_ss = ev[0];
    assign ev_lr = ev[1];

    // Synchronise, debounce (down-counter to terminal count) and edge-detect
    // both buttons. A button only arms after the synchroniser has filled and
    // shown a confirmed low level, so a button held through reset is ignored
    // until it has been released once.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            armed <= '0;
            ev    <= '0;
            fill  <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            fill  <= {fill[0], 1'b1};
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= DEB_LOAD;
                end else if (cnt[i] == '0) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= DEB_LOAD;
                end else begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
                if (fill[1] && !sync2[i] && !deb[i]) begin
                    armed[i] <= 1'b1;
                end
                ev[i] <= deb[i] & ~deb_d[i] & armed[i];
            end
        end
    end

    // Next-state decode; start/stop takes priority over lap/reset.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (ev_ss) state_nx = S_RUN;
            end
            S_RUN: begin
                if (ev_ss)      state_nx = S_STOP;
                else if (ev_lr) state_nx = S_LAP;
            end
            S_LAP: begin
                if (ev_ss)      state_nx = S_STOP;
                else if (ev_lr) state_nx = S_RUN;
            end
            S_STOP: begin
                if (ev_ss)      state_nx = S_RUN;
                else if (ev_lr) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign run_now = (state == S_RUN) || (state == S_LAP);
    assign run_nx  = (state_nx == S_RUN) || (state_nx == S_LAP);

    // State register with registered status outputs and the clear strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            stp      <= 1'b1;
            lap_hold <= 1'b0;
            clr      <= 1'b0;
        end else begin
            state    <= state_nx;
            stp      <= (state_nx == S_IDLE) || (state_nx == S_STOP);
            lap_hold <= (state_nx == S_LAP);
            clr      <= (state == S_STOP) && (state_nx == S_IDLE);
        end
    end

    // Tick prescaler: advances while the current state is counting; the
    // tick is suppressed if the machine leaves RUN/LAP on the wrap edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc <= '0;
            ad    <= 1'b0;
        end else begin
            ad <= 1'b0;
            if (state_nx == S_IDLE) begin
                presc <= '0;
            end else if (run_now) begin
                if (presc == PRE_LAST) begin
                    presc <= '0;
                    ad    <= run_nx;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV=4, DEB_CYC=3.
// Cycle k is sampled on the falling edge after rising edge k following reset
// release; a button set at falling edge P changes the state visible at P+7.
module tb_stopwatch_ctrl;

    logic clk;
    logic reset_n;
    logic btn_ss;
    logic btn_lr;
    logic ad;
    logic stp;
    logic clr;
    logic lap_hold;

    int n_cmp;
    int n_bad;

    stopwatch_ctrl #(.DIV(4), .DEB_CYC(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .btn_ss   (btn_ss),
        .btn_lr   (btn_lr),
        .ad       (ad),
        .stp      (stp),
        .clr      (clr),
        .lap_hold (lap_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset(input logic ss_level);
        btn_ss  = ss_level;
        btn_lr  = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // outputs packed as {ad, stp, clr, lap_hold}
    task automatic test_reset();
        logic [3:0] got;
        btn_ss  = 1'b0;
        btn_lr  = 1'b0;
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            got = {ad, stp, clr, lap_hold};
            n_cmp++;
            if (got !== 4'b0100) begin
                n_bad++;
                $display("FAIL reset_hold k=%0d got %b exp 0100", k, got);
            end
        end
        reset_n = 1'b1;
        // lap/reset from IDLE is a no-op
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            got = {ad, stp, clr, lap_hold};
            n_cmp++;
            if (got !== 4'b0100) begin
                n_bad++;
                $display("FAIL reset_idle_lr k=%0d got %b exp 0100", k, got);
            end
            btn_lr = (k >= 5 && k < 10);
        end
    endtask

    task automatic test_start();
        logic [3:0] got;
        logic [3:0] exp;
        do_reset(1'b0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            exp = {(k >= 16 && (k - 16) % 4 == 0), (k < 12), 1'b0, 1'b0};
            got = {ad, stp, clr, lap_hold};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL start k=%0d got %b exp %b", k, got, exp);
            end
            btn_ss = (k >= 5 && k < 15);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] got;
        logic [3:0] exp;
        do_reset(1'b0);
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            exp = {(k >= 20 && (k - 20) % 4 == 0), (k < 16), 1'b0, 1'b0};
            got = {ad, stp, clr, lap_hold};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL bounce k=%0d got %b exp %b", k, got, exp);
            end
            btn_ss = (k == 5 || k == 7 || (k >= 9 && k < 20));
        end
    endtask

    task automatic test_lap();
        logic [3:0] got;
        logic [3:0] exp;
        do_reset(1'b0);
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            exp = {(k >= 16 && (k - 16) % 4 == 0), (k < 12), 1'b0, (k >= 25 && k < 37)};
            got = {ad, stp, clr, lap_hold};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL lap k=%0d got %b exp %b", k, got, exp);
            end
            btn_ss = (k >= 5 && k < 10);
            btn_lr = (k >= 18 && k < 23) || (k >= 30 && k < 35);
        end
    endtask

    // stop lands with prescaler=2, so resume ticks 2 cycles after stp falls
    task automatic test_stop_resume();
        logic [3:0] got;
        logic [3:0] exp;
        do_reset(1'b0);
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            exp = {(k == 16 || k == 20 || (k >= 39 && (k - 39) % 4 == 0)),
                   (k < 12 || (k >= 22 && k < 37)), 1'b0, 1'b0};
            got = {ad, stp, clr, lap_hold};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL stop_resume k=%0d got %b exp %b", k, got, exp);
            end
            btn_ss = (k >= 5 && k < 10) || (k >= 15 && k < 20) || (k >= 30 && k < 35);
        end
    endtask

    // clear from STOP also zeroes the partial tick: restart ticks 4 cycles later
    task automatic test_clear();
        logic [3:0] got;
        logic [3:0] exp;
        do_reset(1'b0);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            exp = {(k == 16 || k == 20 || (k >= 53 && (k - 53) % 4 == 0)),
                   (k < 12 || (k >= 22 && k < 49)), (k == 35), 1'b0};
            got = {ad, stp, clr, lap_hold};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL clear k=%0d got %b exp %b", k, got, exp);
            end
            btn_ss = (k >= 5 && k < 10) || (k >= 15 && k < 20) || (k >= 42 && k < 47);
            btn_lr = (k >= 28 && k < 33);
        end
    endtask

    // both events together on the prescaler wrap cycle: STOP wins, no tick
    task automatic test_simultaneous();
        logic [3:0] got;
        logic [3:0] exp;
        do_reset(1'b0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            exp = {(k == 16 || k == 20), (k < 12 || k >= 24), 1'b0, 1'b0};
            got = {ad, stp, clr, lap_hold};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL simultaneous k=%0d got %b exp %b", k, got, exp);
            end
            btn_ss = (k >= 5 && k < 10) || (k >= 17 && k < 22);
            btn_lr = (k >= 17 && k < 22);
        end
    endtask

    task automatic test_held_reset();
        logic [3:0] got;
        logic [3:0] exp;
        do_reset(1'b1);
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            exp = {(k >= 36 && (k - 36) % 4 == 0), (k < 32), 1'b0, 1'b0};
            got = {ad, stp, clr, lap_hold};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL held_reset k=%0d got %b exp %b", k, got, exp);
            end
            btn_ss = (k < 15) || (k >= 25 && k < 30);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        btn_ss  = 1'b0;
        btn_lr  = 1'b0;
        test_reset();
        test_start();
        test_bounce();
        test_lap();
        test_stop_resume();
        test_clear();
        test_simultaneous();
        test_held_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
